shift_unit_seq: RTL and testbench

Parametrised multi-cycle shifter, the general successor to the fixed left-shift-by-2 element. It takes a WIDTH-bit operand, a shift amount and an operation (logical left, logical right, arithmetic right, rotate left), and shifts by up to STEP bits per clock. A start/done handshake lets the multicycle MIPS datapath and controller issue shifts (sll/srl/sra/sllv/srlv/srav) without a full barrel shifter in the critical path.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 28 ++
 rtl/shift_unit_seq.sv | 96 +++++++++
 tb/tb_shift_unit_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shifter: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,  // logical left, zero fill on the right
    SRL = 2'b01,  // logical right, zero fill on the left
    SRA = 2'b10,  // arithmetic right, sign bit replicated
    ROL = 2'b11   // rotate left, MSB re-enters at LSB
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// One partial shift step: moves value by k bits (0..STEP) in the direction
// and fill mode selected by op. Purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]           value,
  input  shift_op_t                  op,
  input  logic [$clog2(STEP+1)-1:0]  k,
  output logic [WIDTH-1:0]           result
);

  // Select the k-bit shift of the requested kind.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    result = value;
    unique case (op)
      SLL: result = value << k;
      SRL: result = value >> k;
      SRA: result = WIDTH'($signed(value) >>> k);
      ROL: result = (value << k) | (value >> (WIDTH - int'(k)));
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter with start/done handshake. Shifts a WIDTH-bit operand
// by up to STEP bits per clock until the requested amount is consumed, then
// registers the result into y and pulses done for one cycle.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  shift_op_t        op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  localparam int KW = $clog2(STEP + 1);

  shift_state_t     state, state_next;
  shift_op_t        op_q;
  logic [WIDTH-1:0] work, step_out;
  logic [SHW-1:0]   rem;
  logic [KW-1:0]    k;
  logic             accept, last_step;

  // A new request is taken whenever the unit is not busy shifting.
  assign ready  = (state != SHIFT);
  assign accept = start && ready;

  // Bits to move this cycle: min(STEP, rem). The final step is the one that
  // brings rem to zero.
  assign k         = (rem > SHW'(STEP)) ? KW'(STEP) : rem[KW-1:0];
  assign last_step = (rem <= SHW'(STEP));

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value  (work),
    .op     (op_q),
    .k      (k),
    .result (step_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a zero shift amount goes straight to DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    if (start) state_next = (shamt == '0) ? DONE : SHIFT;
               else       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Remaining count and output registers; y is written only on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem  <= '0;
      y    <= '0;
      done <= 1'b0;
    end else begin
      done <= (state_next == DONE);
      if (state_next == DONE) y <= accept ? a : step_out;
      if (accept)              rem <= shamt;
      else if (state == SHIFT) rem <= rem - SHW'(k);
    end
  end

  // Work register and latched operation.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers carry no reset; they are always loaded
    // on accept before anything reads them, so reset would only cost routing.
    if (accept) begin
      work <= a;
      op_q <= op;
    end else if (state == SHIFT) begin
      work <= step_out;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: three instances (STEP 1, 4, 8)
// driven with directed and random shifts, checked against a reference model.
module tb_shift_unit_seq;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start [3];
  shift_op_t   op    [3];
  logic [31:0] a     [3];
  logic [4:0]  shamt [3];
  logic        ready [3];
  logic        done  [3];
  logic [31:0] y     [3];

  int steps [3] = '{1, 4, 8};
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[0]), .op(op[0]), .a(a[0]),
    .shamt(shamt[0]), .ready(ready[0]), .done(done[0]), .y(y[0]));
  shift_unit_seq #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start[1]), .op(op[1]), .a(a[1]),
    .shamt(shamt[1]), .ready(ready[1]), .done(done[1]), .y(y[1]));
  shift_unit_seq #(.WIDTH(32), .STEP(8)) dut8 (
    .clk(clk), .reset(reset), .start(start[2]), .op(op[2]), .a(a[2]),
    .shamt(shamt[2]), .ready(ready[2]), .done(done[2]), .y(y[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: shift in a 64-bit field and keep the relevant 32-bit window.
  function automatic logic [31:0] ref_shift(shift_op_t o, logic [31:0] v, int s);
    logic [63:0] w;
    case (o)
      SLL:     begin w = {32'b0, v} << s;        return w[31:0];  end
      SRL:     begin w = {32'b0, v} >> s;        return w[31:0];  end
      SRA:     begin w = {{32{v[31]}}, v} >> s;  return w[31:0];  end
      default: begin w = {v, v} << s;            return w[63:32]; end
    endcase
  endfunction

  // Issue one shift on instance i and check latency, result and pulse width.
  task automatic run_op(input int i, input shift_op_t o, input logic [31:0] av,
                        input logic [4:0] s, input logic [31:0] exp_y,
                        input bit glitch, input string tag);
    int lat;
    int exp_lat;
    exp_lat = (int'(s) + steps[i] - 1) / steps[i];
    @(negedge clk);
    check({tag, "_ready_pre"}, 32'(ready[i]), 32'd1);
    start[i] = 1'b1; op[i] = o; a[i] = av; shamt[i] = s;
    @(posedge clk); #1;
    start[i] = 1'b0;
    if (s != 0) check({tag, "_ready_busy"}, 32'(ready[i]), 32'd0);
    lat = 0;
    while (!done[i] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (glitch && lat == 1) begin
        start[i] = 1'b1; a[i] = ~av; op[i] = SLL;
      end else if (glitch && lat == 2) begin
        start[i] = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_y"}, y[i], exp_y);
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done[i]), 32'd0);
    check({tag, "_y_hold"}, y[i], exp_y);
  endtask

  initial begin
    shift_op_t   o1, o2, ro;
    logic [31:0] a1, a2, ra;
    logic [4:0]  s1, s2, rs;
    int          lat;
    bit          saw_done;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; op[i] = SLL; a[i] = '0; shamt[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_y", y[i], 32'h0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_ready", 32'(ready[i]), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;

    // Idle hold: nothing moves while start stays low.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("idle_y", y[0], 32'h0);
      check("idle_done", 32'(done[0]), 32'd0);
      check("idle_ready", 32'(ready[0]), 32'd1);
    end

    // Legacy shift-by-2 and zero-shift pass-through.
    run_op(0, SLL, 32'h4000_0003, 5'd2, 32'h0000_000C, 1'b0, "legacy_sll2");
    run_op(0, SLL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, "zero_shift");

    // Mode coverage with STEP 4.
    run_op(1, SRL, 32'h8000_00F1, 5'd5, 32'h0400_0007, 1'b0, "mode_srl");
    run_op(1, SRA, 32'h8000_00F1, 5'd5, 32'hFC00_0007, 1'b0, "mode_sra");
    run_op(1, ROL, 32'h8000_00F1, 5'd5, 32'h0000_1E30, 1'b0, "mode_rol");
    run_op(1, SLL, 32'h8000_00F1, 5'd5, 32'h0000_1E20, 1'b0, "mode_sll");

    // Boundary shift with STEP 8, start pulsed mid-operation.
    run_op(2, SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b1, "bound_sra31");
    run_op(2, ROL, 32'h8000_0001, 5'd31, 32'hC000_0000, 1'b0, "bound_rol31");

    // Random shifts on every instance against the model.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 12; n++) begin
        ro = shift_op_t'($urandom_range(0, 3));
        ra = $urandom;
        rs = 5'($urandom_range(0, 31));
        run_op(i, ro, ra, rs, ref_shift(ro, ra, int'(rs)), 1'b0, "rand");
      end
    end

    // Back-to-back: start held through the DONE cycle with new operands.
    o1 = shift_op_t'($urandom_range(0, 3)); a1 = $urandom; s1 = 5'($urandom_range(1, 31));
    o2 = shift_op_t'($urandom_range(0, 3)); a2 = $urandom; s2 = 5'($urandom_range(1, 31));
    @(negedge clk);
    start[1] = 1'b1; op[1] = o1; a[1] = a1; shamt[1] = s1;
    @(posedge clk); #1;
    op[1] = o2; a[1] = a2; shamt[1] = s2;
    lat = 0;
    while (!done[1] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat1", 32'(lat), 32'((int'(s1) + 3) / 4));
    check("b2b_y1", y[1], ref_shift(o1, a1, int'(s1)));
    check("b2b_ready_done", 32'(ready[1]), 32'd1);
    @(posedge clk); #1;
    start[1] = 1'b0;
    check("b2b_pulse1", 32'(done[1]), 32'd0);
    check("b2b_no_idle", 32'(ready[1]), 32'd0);
    lat = 0;
    while (!done[1] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat2", 32'(lat), 32'((int'(s2) + 3) / 4));
    check("b2b_y2", y[1], ref_shift(o2, a2, int'(s2)));
    @(posedge clk); #1;
    check("b2b_pulse2", 32'(done[1]), 32'd0);

    // Reset mid-operation: SLL by 20 on STEP 1, reset sampled at T+7.
    run_op(0, SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0, "pre_reset");
    @(negedge clk);
    start[0] = 1'b1; op[0] = SLL; a[0] = $urandom | 32'h1; shamt[0] = 5'd20;
    @(posedge clk); #1;
    start[0] = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done[0]) saw_done = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_y", y[0], 32'h0);
    check("midrst_ready", 32'(ready[0]), 32'd1);
    check("midrst_done", 32'(done[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done[0]) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    check("midrst_y_after", y[0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
